// File: rtl/fc_seq_pkg.sv
// rtl/fc_seq_pkg.sv - shared states, defaults and helpers for the FC layer sequencer
package fc_seq_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_IN     = 128;
  localparam int DEF_NOUT   = 10;
  localparam int DEF_OW     = 22;
  localparam int DEF_SETTLE = 2;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_result_bank.sv
// rtl/fc_result_bank.sv - NOUT x OW capture registers with indexed read
module fc_result_bank #(
  parameter int NOUT = 10,
  parameter int OW   = 22,
  parameter int IW   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      capture_i,
  input  logic [NOUT-1:0][OW-1:0]   z_i,
  input  logic [IW-1:0]             rd_idx_i,
  output logic [OW-1:0]             rd_data_o
);

  logic [NOUT-1:0][OW-1:0] bank_q;

  // Snapshot every neuron result at once; the bank is only written on capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q <= '0;
    end else if (capture_i) begin
      bank_q <= z_i;
    end
  end

  assign rd_data_o = bank_q[rd_idx_i];

endmodule

// File: rtl/fc_layer_seq.sv
// rtl/fc_layer_seq.sv - loads an activation vector, waits for neuron trees, drains results
module fc_layer_seq
  import fc_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int IN     = DEF_IN,
  parameter int NOUT   = DEF_NOUT,
  parameter int OW     = DEF_OW,
  parameter int SETTLE = DEF_SETTLE,
  localparam int CW    = idx_w(IN),
  localparam int IW    = idx_w(NOUT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic [IN-1:0][WIDTH-1:0]    x,
  input  logic [NOUT-1:0][OW-1:0]     z,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OW-1:0]               out_data,
  output logic [IW-1:0]               out_idx,
  output logic                        out_last,
  output logic                        busy
);

  localparam logic [CW-1:0] CNT_LAST    = CW'(IN - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NOUT - 1);

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [IN-1:0][WIDTH-1:0] x_q;
  logic                     capture;

  // State, shared load/settle counter and drain index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Sequencing: accept IN beats, let the trees settle, capture once, then drain.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        idx_d   = '0;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Activation vector is only written by accepted beats, so it is frozen outside LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
    end else if (state_q == ST_LOAD && in_valid) begin
      x_q[cnt_q] <= in_data;
    end
  end

  fc_result_bank #(
    .NOUT (NOUT),
    .OW   (OW),
    .IW   (IW)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .capture_i (capture),
    .z_i       (z),
    .rd_idx_i  (idx_q),
    .rd_data_o (out_data)
  );

  assign x        = x_q;
  assign out_idx  = idx_q;
  assign out_last = (state_q == ST_DRAIN) && (idx_q == IDX_LAST);
  assign busy     = !((state_q == ST_LOAD) && (cnt_q == '0));

endmodule

// File: tb/tb_fc_layer_seq.sv
// tb/tb_fc_layer_seq.sv - directed bench with a frame-level reference model
module tb_fc_layer_seq;

  localparam int IN     = 128;
  localparam int NOUT   = 10;
  localparam int OW     = 22;
  localparam int SETTLE = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [7:0]              in_data = '0;
  logic [IN-1:0][7:0]      x;
  logic [NOUT-1:0][OW-1:0] z = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [OW-1:0]           out_data;
  logic [3:0]              out_idx;
  logic                    out_last;
  logic                    busy;

  logic                    s_in_valid = 1'b0;
  logic                    s_in_ready;
  logic [7:0]              s_in_data = '0;
  logic [3:0][7:0]         s_x;
  logic [0:0][OW-1:0]      s_z = '0;
  logic                    s_out_valid;
  logic                    s_out_ready = 1'b0;
  logic [OW-1:0]           s_out_data;
  logic [0:0]              s_out_idx;
  logic                    s_out_last;
  logic                    s_busy;

  int n_vec = 0;
  int n_err = 0;

  logic [OW-1:0] exp_beat [NOUT];

  always #5 clk = ~clk;

  fc_layer_seq #(.WIDTH(8), .IN(IN), .NOUT(NOUT), .OW(OW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .x(x), .z(z), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  fc_layer_seq #(.WIDTH(8), .IN(4), .NOUT(1), .OW(OW), .SETTLE(0)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .x(s_x), .z(s_z), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_idx(s_out_idx), .out_last(s_out_last), .busy(s_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: phase 0 loading, 1 waiting for trees, 2 draining.
  int            m_phase, m_cnt, m_wait, m_idx;
  logic [7:0]    m_x    [IN];
  logic [OW-1:0] m_bank [NOUT];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_wait  <= 0;
      m_idx   <= 0;
      foreach (m_x[i]) m_x[i] <= '0;
      foreach (m_bank[i]) m_bank[i] <= '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_x[m_cnt] <= in_data;
          if (m_cnt == IN - 1) begin
            m_phase <= 1;
            m_wait  <= 0;
            m_cnt   <= 0;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        1: if (m_wait == SETTLE) begin
          foreach (m_bank[i]) m_bank[i] <= z[i];
          m_phase <= 2;
          m_idx   <= 0;
        end else begin
          m_wait <= m_wait + 1;
        end
        default: if (out_ready) begin
          if (m_idx == NOUT - 1) m_phase <= 0;
          else m_idx <= m_idx + 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    int xi;
    if (!rst) begin
      check("in_ready", in_ready, m_phase == 0);
      check("out_valid", out_valid, m_phase == 2);
      check("busy", busy, !(m_phase == 0 && m_cnt == 0));
      check("out_last", out_last, m_phase == 2 && m_idx == NOUT - 1);
      if (m_phase == 2) begin
        check("out_idx", out_idx, m_idx);
        check("out_data", out_data, m_bank[m_idx]);
      end
      xi = 0;
      for (int i = 0; i < IN; i++) begin
        if (x[i] !== m_x[i]) begin
          xi = i;
          break;
        end
      end
      check("x_elem", x[xi], m_x[xi]);
    end
  end

  task automatic put(input logic [7:0] d);
    int   g;
    logic acc;
    g = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    while (!acc && g < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    in_valid = 1'b0;
    if (!acc) check("put_timeout", acc, 1'b1);
  endtask

  task automatic drain(input int stall_at);
    int g, k;
    bit first, stalled;
    g = 0;
    k = 0;
    first = 1'b1;
    stalled = 1'b0;
    out_ready = 1'b1;
    while (k < NOUT && g < 3000) begin
      if (!first) @(negedge clk);
      first = 1'b0;
      g++;
      if (out_valid && !stalled && stall_at >= 0 && out_idx == stall_at) begin
        out_ready = 1'b0;
        stalled = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1'b1);
          check("stall_idx", out_idx, stall_at);
          check("stall_data", out_data, exp_beat[stall_at]);
        end
        out_ready = 1'b1;
      end
      if (out_valid) begin
        check("beat_idx", out_idx, k);
        check("beat_data", out_data, exp_beat[k]);
        check("beat_last", out_last, k == NOUT - 1);
        k++;
      end
    end
    if (k < NOUT) check("drain_timeout", k, NOUT);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_x_zero", x == '0, 1'b1);
    @(posedge clk);
    #1;

    // Single-neuron, zero-settle variant: capture follows the last beat directly.
    s_z[0] = 22'h2ABCD;
    for (int k = 0; k < 4; k++) begin
      s_in_valid = 1'b1;
      s_in_data = 8'(8'h10 + k);
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    @(negedge clk);
    check("s_capture_gap", s_out_valid, 1'b0);
    check("s_x", s_x, 32'h13121110);
    @(negedge clk);
    check("s_valid", s_out_valid, 1'b1);
    check("s_last", s_out_last, 1'b1);
    check("s_idx", s_out_idx, 0);
    check("s_data", s_out_data, 22'h2ABCD);
    s_out_ready = 1'b1;
    @(posedge clk);
    #1;
    s_out_ready = 1'b0;
    @(negedge clk);
    check("s_done", s_out_valid, 1'b0);
    check("s_ready", s_in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Continuous ones, z = 0..9, latency to first result.
    for (int k = 0; k < NOUT; k++) begin
      z[k] = OW'(k);
      exp_beat[k] = OW'(k);
    end
    for (int k = 0; k < IN; k++) put(8'd1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("latency", n + 1, SETTLE + 2);
    drain(-1);

    // Gapped load of k.
    for (int k = 0; k < NOUT; k++) begin
      z[k] = OW'(100 + 7 * k);
      exp_beat[k] = OW'(100 + 7 * k);
    end
    for (int k = 0; k < IN; k++) begin
      put(8'(k));
      @(posedge clk);
      #1;
    end
    check("gap_x0", x[0], 8'h00);
    check("gap_x77", x[77], 8'd77);
    check("gap_x127", x[127], 8'd127);
    drain(-1);

    // Back-pressure on beat 3, results at the top of the range.
    for (int k = 0; k < NOUT; k++) begin
      z[k] = OW'(22'h3FFFFF - k);
      exp_beat[k] = OW'(22'h3FFFFF - k);
    end
    for (int k = 0; k < IN; k++) put(8'hFF);
    drain(3);

    // z wanders during settle, is final before capture, wanders again during drain.
    for (int k = 0; k < NOUT; k++) z[k] = OW'(22'h155555);
    for (int k = 0; k < IN; k++) put(8'(3 * k));
    for (int k = 0; k < NOUT; k++) z[k] = OW'(22'h0AAAAA + k);
    @(posedge clk);
    #1;
    for (int k = 0; k < NOUT; k++) begin
      z[k] = OW'(1000 + k);
      exp_beat[k] = OW'(1000 + k);
    end
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < NOUT; k++) z[k] = '1;
    drain(-1);

    // Reset in the middle of a load, then a clean frame.
    for (int k = 0; k < 60; k++) put(8'(k + 1));
    rst = 1'b1;
    #3;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_idx", out_idx, 0);
    check("mid_rst_out_last", out_last, 1'b0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_x_zero", x == '0, 1'b1);
    @(posedge clk);
    #1;
    for (int k = 0; k < NOUT; k++) begin
      z[k] = OW'(5000 + 3 * k);
      exp_beat[k] = OW'(5000 + 3 * k);
    end
    for (int k = 0; k < IN; k++) put(8'(k) ^ 8'h5A);
    drain(-1);

    // Back-to-back frames: the producer waits with in_valid high during drain.
    for (int k = 0; k < IN; k++) put(8'(k));
    fork
      drain(-1);
      begin
        for (int k = 0; k < IN; k++) put(8'(k + 3));
      end
    join
    check("b2b_x0", x[0], 8'h03);
    check("b2b_x127", x[127], 8'h82);
    drain(-1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fc_layer_seq.md
FC_LAYER_SEQ -- requirements
Module: fc_layer_seq

Interface
REQ-001 Parameters: WIDTH, default 8, activation width; IN, default 128, input vector length; NOUT, default 10, neurons per layer; OW, default 22, neuron result width (WIDTH*2 plus adder-tree growth); SETTLE, default 2, cycles the combinational neuron trees are allowed to settle.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  input activation beat valid.
REQ-005 in_ready  output  1  block accepts an activation beat.
REQ-006 in_data  input  WIDTH  activation, unsigned, element order 0..IN-1.
REQ-007 x  output  IN x WIDTH  registered activation vector driving every neuron instance.
REQ-008 z  input  NOUT x OW  neuron results (post-ReLU, unsigned).
REQ-009 out_valid  output  1  result beat valid.
REQ-010 out_ready  input  1  downstream accepts result beat.
REQ-011 out_data  output  OW  captured result of neuron out_idx.
REQ-012 out_idx  output  clog2(NOUT)  neuron index of current beat.
REQ-013 out_last  output  1  high on beat out_idx == NOUT-1.
REQ-014 busy  output  1  high in any state other than LOAD with count 0.

Function
REQ-015 FSM states: LOAD, SETTLE, CAPTURE, DRAIN; reset state LOAD.
REQ-016 LOAD: in_ready = 1; each in_valid&in_ready beat writes in_data to x[cnt] and increments cnt; beat at cnt == IN-1 moves to SETTLE with cnt cleared.
REQ-017 SETTLE: in_ready = 0; x frozen; counter runs SETTLE cycles, then CAPTURE.
REQ-018 CAPTURE: one cycle; all NOUT z values latched into a result register bank; next state DRAIN, out_idx = 0.
REQ-019 DRAIN: out_valid = 1; out_data = bank[out_idx]; out_idx advances only on out_valid&out_ready; handshake on last beat returns to LOAD with cnt = 0.
REQ-020 out_data, out_idx, out_last hold stable while out_valid & !out_ready.
REQ-021 x is never written outside LOAD; z sampled only in CAPTURE (multicycle path of SETTLE+1 cycles).
REQ-022 in_valid outside LOAD is ignored and not lost-accounted; producer holds data until in_ready.
REQ-023 Total latency last input beat to first out_valid: SETTLE+2 cycles.
REQ-024 SETTLE = 0 SHALL be legal: SETTLE state skipped, LOAD goes directly to CAPTURE.
REQ-025 cnt width clog2(IN); no wrap beyond IN-1.
REQ-026 NOUT = 1: first drain beat has out_last = 1.

Reset
REQ-027 On rst: state LOAD, cnt 0, in_ready 1 after release, out_valid 0, out_idx 0, out_last 0, out_data 0, busy 0, x all zero, result bank zero.
REQ-028 rst asserted mid-LOAD or mid-DRAIN aborts the frame; partial vector and undrained results discarded.

Structure
REQ-029 Package fc_seq_pkg holds state enum, default WIDTH/IN/NOUT/OW constants.
REQ-030 One sub-module natural: fc_result_bank (NOUT x OW capture registers with indexed read).
REQ-031 Neuron instances live outside this block; x and z are the only datapath connections.

Verification
REQ-032 Load 128 beats of value 1 continuous, z tied to 0..9 -> out_valid at cycle 128+SETTLE+2, beats 0..9 in order, out_last on beat 9.
REQ-033 Gapped in_valid (every other cycle) -> x[k] == k&0xFF after load; same result ordering.
REQ-034 out_ready low for 5 cycles on beat 3 -> out_data/out_idx held, no beat skipped or duplicated.
REQ-035 z changed during SETTLE, fixed before CAPTURE -> captured values equal last-cycle z; later z changes do not affect drain.
REQ-036 rst pulsed after 60 input beats -> outputs at reset values; next full 128-beat frame drains correctly.
REQ-037 Back-to-back frames, in_valid held high during DRAIN -> no beat accepted until LOAD; second frame x correct.
